// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: feeder FSM states,
// kernel size, and the window slot index used to pack/unpack 3x3 windows.
package conv_pkg;

  localparam int KERNEL = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    OUT     = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Slot of window element (r, c); r = 0 is the top row, c = 0 the leftmost column.
  function automatic int win_idx(input int r, input int c);
    return KERNEL * r + c;
  endfunction

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// One image row of pixel storage, indexed by column.
// Writes are synchronous; the read is combinational so a capture sees the old value.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Column write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/conv_window_feeder.sv
// Streams a frame from memory in raster order and hands out every 3x3
// window over a valid/ready handshake.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              mem_rd,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic [DATA_W-1:0]                 mem_data,
  output logic [KERNEL*KERNEL*DATA_W-1:0]   win_data,
  output logic                              win_valid,
  input  logic                              win_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int X_W   = $clog2(IMG_W);
  localparam int Y_W   = $clog2(IMG_H);
  localparam int WIN_W = KERNEL * KERNEL * DATA_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
  localparam logic [X_W-1:0]    X_EMIT    = X_W'(KERNEL - 1);
  localparam logic [Y_W-1:0]    Y_EMIT    = Y_W'(KERNEL - 1);

  state_t              state_r, state_next;
  logic [X_W-1:0]      x_r;
  logic [Y_W-1:0]      y_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [WIN_W-1:0]    win_r, win_next_s, win_data_r;
  logic [DATA_W-1:0]   lb_a_rd_s, lb_b_rd_s;
  logic                mem_rd_r, win_valid_r, busy_r, done_r;
  logic                capture_s, advance_s, clear_s, emit_s, last_s;

  assign emit_s = (y_r >= Y_EMIT) && (x_r >= X_EMIT);
  assign last_s = (addr_r == LAST_ADDR);

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .IDX_W(X_W)) u_lb_a (
    .clk   (clk),
    .we    (capture_s),
    .idx   (x_r),
    .wdata (mem_data),
    .rdata (lb_a_rd_s)
  );

  // lb_b inherits whatever lb_a held for this column, i.e. two rows up.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .IDX_W(X_W)) u_lb_b (
    .clk   (clk),
    .we    (capture_s),
    .idx   (x_r),
    .wdata (lb_a_rd_s),
    .rdata (lb_b_rd_s)
  );

  // Window after a capture: shift columns left, new right column from buffers and pixel.
  always_comb begin
    win_next_s = win_r;
    for (int r = 0; r < KERNEL; r++) begin
      win_next_s[DATA_W*win_idx(r, 0) +: DATA_W] = win_r[DATA_W*win_idx(r, 1) +: DATA_W];
      win_next_s[DATA_W*win_idx(r, 1) +: DATA_W] = win_r[DATA_W*win_idx(r, 2) +: DATA_W];
    end
    win_next_s[DATA_W*win_idx(0, 2) +: DATA_W] = lb_b_rd_s;
    win_next_s[DATA_W*win_idx(1, 2) +: DATA_W] = lb_a_rd_s;
    win_next_s[DATA_W*win_idx(2, 2) +: DATA_W] = mem_data;
  end

  // Next-state and counter control.
  always_comb begin
    state_next = state_r;
    capture_s  = 1'b0;
    advance_s  = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next = READ;
          clear_s    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      READ: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        capture_s = 1'b1;
        if (emit_s) begin
          state_next = OUT;
        end else if (last_s) begin
          state_next = DONE;
        end else begin
          advance_s  = 1'b1;
          state_next = READ;
        end
      end
      OUT: begin
        if (win_ready) begin
          if (last_s) begin
            state_next = DONE;
          end else begin
            advance_s  = 1'b1;
            state_next = READ;
          end
        end else begin
          state_next = OUT;
        end
      end
      DONE: begin
        state_next = IDLE;
        clear_s    = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pixel position and address; the last pixel never advances, so no wrap.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      x_r    <= '0;
      y_r    <= '0;
      addr_r <= '0;
    end else if (advance_s) begin
      addr_r <= addr_r + ADDR_W'(1);
      if (x_r == X_LAST) begin
        x_r <= '0;
        y_r <= y_r + Y_W'(1);
      end else begin
        x_r <= x_r + X_W'(1);
      end
    end
  end

  // Working window register, unreset like the line buffers.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      win_r <= win_next_s;
    end
  end

  // State register and outputs decoded from the next state so they come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_rd_r    <= 1'b0;
      win_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      win_data_r  <= '0;
    end else begin
      state_r     <= state_next;
      mem_rd_r    <= (state_next == READ);
      win_valid_r <= (state_next == OUT);
      busy_r      <= (state_next != IDLE);
      done_r      <= (state_next == DONE);
      if (capture_s && emit_s) begin
        win_data_r <= win_next_s;
      end
    end
  end

  assign mem_rd    = mem_rd_r;
  assign mem_addr  = addr_r;
  assign win_data  = win_data_r;
  assign win_valid = win_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: 4x4 instance checked every cycle against an
// image-arithmetic model, plus 3x3 and 5x3 instances with literal expectations.
module tb_conv_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start4, rd4, valid4, ready4, busy4, done4;
  logic [3:0]  addr4;
  logic [7:0]  data4;
  logic [71:0] win4;

  logic        start3, rd3, valid3, ready3, busy3, done3;
  logic [3:0]  addr3;
  logic [7:0]  data3;
  logic [71:0] win3;

  logic        start53, rd53, valid53, ready53, busy53, done53;
  logic [3:0]  addr53;
  logic [7:0]  data53;
  logic [71:0] win53;

  conv_window_feeder #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .mem_rd(rd4), .mem_addr(addr4),
    .mem_data(data4), .win_data(win4), .win_valid(valid4), .win_ready(ready4),
    .busy(busy4), .done(done4));

  conv_window_feeder #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .mem_rd(rd3), .mem_addr(addr3),
    .mem_data(data3), .win_data(win3), .win_valid(valid3), .win_ready(ready3),
    .busy(busy3), .done(done3));

  conv_window_feeder #(.DATA_W(8), .IMG_W(5), .IMG_H(3)) u53 (
    .clk(clk), .rst(rst), .start(start53), .mem_rd(rd53), .mem_addr(addr53),
    .mem_data(data53), .win_data(win53), .win_valid(valid53), .win_ready(ready53),
    .busy(busy53), .done(done53));

  // Memories return pixel = address one cycle after the read strobe.
  always @(posedge clk) begin
    data4  <= rd4  ? 8'(addr4)  : 8'hEE;
    data3  <= rd3  ? 8'(addr3)  : 8'hEE;
    data53 <= rd53 ? 8'(addr53) : 8'hEE;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Window whose bottom-right pixel is (y,x) in a width-w image with pixel = address.
  function automatic logic [71:0] exp_win(input int w, input int y, input int x);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[8*(3*r+c) +: 8] = 8'((y - 2 + r) * w + (x - 2 + c));
    return v;
  endfunction

  logic [71:0] exp_q[$];
  logic [71:0] got4[$];
  logic [71:0] got3[$];
  logic [71:0] got53[$];
  int          rd_count = 0;
  int          done_count = 0;
  int          done_base = 0;
  logic        prev_valid = 1'b0;
  logic        prev_xfer = 1'b0;
  logic [71:0] prev_data = '0;

  task automatic start_frame4();
    exp_q.delete();
    got4.delete();
    rd_count  = 0;
    done_base = done_count;
    for (int y = 2; y < 4; y++)
      for (int x = 2; x < 4; x++)
        exp_q.push_back(exp_win(4, y, x));
  endtask

  // Per-cycle comparison of the 4x4 instance against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (prev_valid && !prev_xfer) begin
        chk("valid_hold", 128'(valid4), 128'(1));
        chk("data_stable", 128'(win4), 128'(prev_data));
      end
      if (valid4) chk("rd_during_out", 128'(rd4), 128'(0));
      if (rd4) begin
        chk("rd_addr", 128'(addr4), 128'(rd_count));
        rd_count++;
      end
      if (valid4 && ready4) begin
        got4.push_back(win4);
        if (exp_q.size() == 0) chk("win_extra", 128'(exp_q.size()), 128'(1));
        else chk("win_data", 128'(win4), 128'(exp_q.pop_front()));
      end
      if (done4) begin
        done_count++;
        chk("done_reads", 128'(rd_count), 128'(16));
        chk("done_left", 128'(exp_q.size()), 128'(0));
      end
      prev_valid = valid4;
      prev_xfer  = valid4 && ready4;
      prev_data  = win4;
    end
    if (valid3 && ready3)   got3.push_back(win3);
    if (valid53 && ready53) got53.push_back(win53);
  end

  task automatic pulse4();
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic wait_done4(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (done4) seen = 1'b1;
    end
    chk(name, 128'(seen), 128'(1));
  endtask

  task automatic wait_valid4(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (valid4) seen = 1'b1;
    end
    chk(name, 128'(seen), 128'(1));
  endtask

  task automatic post_frame4(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_count"}, 128'(got4.size()), 128'(4));
    chk({name, "_done_once"}, 128'(done_count - done_base), 128'(1));
    chk({name, "_idle"}, 128'(busy4), 128'(0));
    if (got4.size() == 4) begin
      chk({name, "_first"}, 128'(got4[0]), 128'(72'h0a0908060504020100));
      chk({name, "_last"}, 128'(got4[3]), 128'(72'h0f0e0d0b0a09070605));
    end
  endtask

  task automatic chk_reset4(input string name);
    chk({name, "_rd"}, 128'(rd4), 128'(0));
    chk({name, "_addr"}, 128'(addr4), 128'(0));
    chk({name, "_valid"}, 128'(valid4), 128'(0));
    chk({name, "_data"}, 128'(win4), 128'(0));
    chk({name, "_busy"}, 128'(busy4), 128'(0));
    chk({name, "_done"}, 128'(done4), 128'(0));
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    start4 = 1'b0; start3 = 1'b0; start53 = 1'b0;
    ready4 = 1'b1; ready3 = 1'b1; ready53 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset4("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain 4x4 frame.
    start_frame4();
    pulse4();
    wait_done4("t1_done_timeout");
    post_frame4("t1");

    // Backpressure on the first window.
    start_frame4();
    ready4 = 1'b0;
    pulse4();
    wait_valid4("stall_valid_timeout");
    repeat (4) begin
      @(posedge clk); #1;
      chk("stall_valid", 128'(valid4), 128'(1));
      chk("stall_rd", 128'(rd4), 128'(0));
    end
    ready4 = 1'b1;
    wait_done4("stall_done_timeout");
    post_frame4("stall");

    // A second start mid-frame must change nothing.
    start_frame4();
    pulse4();
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 128'(busy4), 128'(1));
    pulse4();
    wait_done4("mid_done_timeout");
    post_frame4("mid");

    // Reset while the second window is waiting, then a full restart.
    start_frame4();
    pulse4();
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (got4.size() == 1) seen = 1'b1;
    end
    chk("rst_first_timeout", 128'(seen), 128'(1));
    ready4 = 1'b0;
    wait_valid4("rst_valid_timeout");
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset4("midrst");
    rst = 1'b0;
    ready4 = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", 128'(busy4), 128'(0));
    start_frame4();
    pulse4();
    wait_done4("restart_done_timeout");
    post_frame4("restart");

    // 3x3: a single window, done one cycle after acceptance.
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (valid3) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t3_valid_timeout", 128'(seen), 128'(1));
    @(posedge clk); #1;
    chk("t3_done", 128'(done3), 128'(1));
    chk("t3_valid_drop", 128'(valid3), 128'(0));
    @(posedge clk); #1;
    chk("t3_done_pulse", 128'(done3), 128'(0));
    chk("t3_busy_low", 128'(busy3), 128'(0));
    chk("t3_count", 128'(got3.size()), 128'(1));
    if (got3.size() == 1) chk("t3_window", 128'(got3[0]), 128'(72'h080706050403020100));

    // 5x3 non-square frame.
    start53 = 1'b1;
    @(posedge clk); #1;
    start53 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (done53) seen = 1'b1;
    end
    chk("t53_done_timeout", 128'(seen), 128'(1));
    chk("t53_count", 128'(got53.size()), 128'(3));
    if (got53.size() == 3) begin
      chk("t53_window0", 128'(got53[0]), 128'(72'h0c0b0a070605020100));
      chk("t53_br0", 128'(got53[0][71:64]), 128'(8'd12));
      chk("t53_br1", 128'(got53[1][71:64]), 128'(8'd13));
      chk("t53_br2", 128'(got53[2][71:64]), 128'(8'd14));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
